// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared access-size encodings, MMIO offsets and alignment helper
package dmem_mmio_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 32;

    typedef enum logic [1:0] {
        WHB_WORD = 2'b00,
        WHB_HALF = 2'b01,
        WHB_BYTE = 2'b10,
        WHB_RSVD = 2'b11
    } whb_t;

    localparam logic [7:0] OFF_CYCLE = 8'h00;
    localparam logic [7:0] OFF_LED   = 8'h04;
    localparam logic [7:0] OFF_FAULT = 8'h08;
    localparam logic [7:0] OFF_FPC   = 8'h0C;

    // Reserved size is never misaligned: such stores are dropped silently.
    function automatic logic is_misaligned(input logic [1:0] whb, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (whb)
            WHB_WORD: r = (addr_lo != 2'b00);
            WHB_HALF: r = addr_lo[0];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enables/lane replication and load extract/extend
module dmem_lane_align
    import dmem_mmio_pkg::*;
(
    input  logic [1:0]      i_addr_lo,
    input  logic [1:0]      i_whb,
    input  logic            i_lunsigned,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rword,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata_sh,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_misaligned
);

    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    assign o_misaligned = is_misaligned(i_whb, i_addr_lo);

    // Data is replicated across lanes so the byte-enables alone pick the target lane.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata_sh = i_wdata;
        case (i_whb)
            WHB_WORD: o_be = 4'b1111;
            WHB_HALF: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_sh = {2{i_wdata[15:0]}};
            end
            WHB_BYTE: begin
                o_be       = 4'b0001 << i_addr_lo;
                o_wdata_sh = {4{i_wdata[7:0]}};
            end
            default: o_be = 4'b0000;
        endcase
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_rbyte = i_rword[7:0];
            2'd1:    w_rbyte = i_rword[15:8];
            2'd2:    w_rbyte = i_rword[23:16];
            default: w_rbyte = i_rword[31:24];
        endcase
        w_rhalf = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        case (i_whb)
            WHB_HALF: o_rdata = {{16{w_rhalf[15] & ~i_lunsigned}}, w_rhalf};
            WHB_BYTE: o_rdata = {{24{w_rbyte[7] & ~i_lunsigned}}, w_rbyte};
            default:  o_rdata = i_rword;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data memory with combinational reads plus cycle/LED/fault MMIO window
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          AW        = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_memwrite,
    input  logic [31:0]     i_daddr,
    input  logic [31:0]     i_writedata,
    input  logic [1:0]      i_whb,
    input  logic            i_lunsigned,
    input  logic [31:0]     i_pc,
    output logic [31:0]     o_readdata,
    output logic [15:0]     o_leds,
    output logic            o_fault,
    output logic [31:0]     o_fault_pc
);

    logic [31:0]   r_mem [0:(2**AW)-1];
    logic [31:0]   r_cycle_cnt;
    logic [15:0]   r_leds;
    logic          r_fault;
    logic [31:0]   r_fault_pc;

    logic          w_mmio_sel;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rword;
    logic [31:0]   w_mmio_word;
    logic          w_misaligned;
    logic          w_ram_we;
    logic          w_mmio_word_we;
    logic          w_bad_store;

    assign w_mmio_sel = (i_daddr[31:8] == MMIO_BASE[31:8]);
    assign w_idx      = i_daddr[AW+1:2];

    dmem_lane_align u_align (
        .i_addr_lo    (i_daddr[1:0]),
        .i_whb        (i_whb),
        .i_lunsigned  (i_lunsigned),
        .i_wdata      (i_writedata),
        .i_rword      (w_rword),
        .o_be         (w_be),
        .o_wdata_sh   (w_wdata_sh),
        .o_rdata      (o_readdata),
        .o_misaligned (w_misaligned)
    );

    // Word offset only: misaligned MMIO loads ignore daddr[1:0] like RAM loads.
    always_comb begin
        case (i_daddr[7:2])
            OFF_CYCLE[7:2]: w_mmio_word = r_cycle_cnt;
            OFF_LED[7:2]:   w_mmio_word = {16'b0, r_leds};
            OFF_FAULT[7:2]: w_mmio_word = {31'b0, r_fault};
            OFF_FPC[7:2]:   w_mmio_word = r_fault_pc;
            default:        w_mmio_word = 32'b0;
        endcase
    end

    assign w_rword = w_mmio_sel ? w_mmio_word : r_mem[w_idx];

    assign w_bad_store    = i_memwrite & w_misaligned;
    assign w_ram_we       = i_memwrite & ~w_mmio_sel & ~w_misaligned;
    assign w_mmio_word_we = i_memwrite & w_mmio_sel & (i_whb == WHB_WORD) & ~w_misaligned;

    // RAM is deliberately not reset: a store in the reset cycle still lands.
    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_cnt <= 32'b0;
            r_leds      <= 16'b0;
            r_fault     <= 1'b0;
            r_fault_pc  <= 32'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_mmio_word_we && (i_daddr[7:0] == OFF_LED)) begin
                r_leds <= i_writedata[15:0];
            end
            if (w_bad_store) begin
                r_fault <= 1'b1;
                if (!r_fault) begin
                    r_fault_pc <= i_pc;
                end
            end else if (w_mmio_word_we && (i_daddr[7:0] == OFF_FAULT) && i_writedata[0]) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign o_leds     = r_leds;
    assign o_fault    = r_fault;
    assign o_fault_pc = r_fault_pc;

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - vector table, corner sequences and random ops against a byte-level model
module tb_dmem_mmio;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset, memwrite, lunsigned;
    logic [31:0] daddr, writedata, pc;
    logic [1:0]  whb;
    logic [31:0] readdata, fault_pc;
    logic [15:0] leds;
    logic        fault;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  m_bytes [0:4095];
    logic [15:0] m_leds;
    logic        m_fault;
    logic [31:0] m_fpc;
    int unsigned ticks = 0;
    int unsigned rst_tick = 0;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  whb;
        bit          lun;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    dmem_mmio dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_memwrite  (memwrite),
        .i_daddr     (daddr),
        .i_writedata (writedata),
        .i_whb       (whb),
        .i_lunsigned (lunsigned),
        .i_pc        (pc),
        .o_readdata  (readdata),
        .o_leds      (leds),
        .o_fault     (fault),
        .o_fault_pc  (fault_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ticks = ticks + 1;
        if (reset) rst_tick = ticks;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz, input bit lun);
        logic [31:0] w, v, mask;
        int base, sh, nbytes;
        if (a[31:8] == 24'hFFFF00) begin
            case (a[7:2])
                6'd0:    w = ticks - rst_tick;
                6'd1:    w = {16'b0, m_leds};
                6'd2:    w = {31'b0, m_fault};
                6'd3:    w = m_fpc;
                default: w = 32'b0;
            endcase
        end else begin
            base = int'((a >> 2) % 1024) * 4;
            w = {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
        end
        nbytes = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
        sh     = (nbytes == 1) ? 8 * int'(a % 4) : (nbytes == 2) ? 16 * int'((a / 2) % 2) : 0;
        v      = w >> sh;
        if (nbytes == 4) return v;
        mask = (32'd1 << (8 * nbytes)) - 1;
        v = v & mask;
        if (!lun && v[8*nbytes-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic m_write(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic [31:0] p);
        int nbytes, base;
        bit mmio;
        mmio = (a[31:8] == 24'hFFFF00);
        if (we && sz != 2'b11) begin
            nbytes = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
            if ((a % nbytes) != 0) begin
                if (!rst) begin
                    if (!m_fault) m_fpc = p;
                    m_fault = 1'b1;
                end
            end else if (mmio) begin
                if (!rst && nbytes == 4) begin
                    if (a[7:0] == 8'h04) m_leds = wd[15:0];
                    if (a[7:0] == 8'h08 && wd[0]) m_fault = 1'b0;
                end
            end else begin
                base = int'((a >> 2) % 1024) * 4;
                for (int k = 0; k < nbytes; k++)
                    m_bytes[base + int'(a % 4) + k] = wd[8*k +: 8];
            end
        end
        if (rst) begin
            m_leds  = 16'b0;
            m_fault = 1'b0;
            m_fpc   = 32'b0;
        end
    endtask

    task automatic do_op(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit lun, input logic [31:0] p, input bit en,
                         output logic [31:0] rd);
        @(negedge clk);
        reset = rst; memwrite = we; daddr = a; writedata = wd; whb = sz; lunsigned = lun; pc = p;
        #1;
        rd = readdata;
        if (en) begin
            chk("readdata_model", readdata, m_read(a, sz, lun));
            chk("leds_model", {16'b0, leds}, {16'b0, m_leds});
            chk("fault_model", {31'b0, fault}, {31'b0, m_fault});
            chk("fault_pc_model", fault_pc, m_fpc);
        end
        @(posedge clk);
        m_write(rst, we, a, wd, sz, p);
        #1;
        reset = 1'b0; memwrite = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] ra;
    int          r;

    initial begin
        reset = 1'b1; memwrite = 1'b0; daddr = '0; writedata = '0; whb = 2'b00; lunsigned = 1'b0; pc = '0;
        // Fill RAM with zeros under reset so every location is known.
        for (int i = 0; i < 1024; i++) do_op(1'b1, 1'b1, i * 4, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, rd);
        chk("reset_leds", {16'b0, leds}, 32'h0);
        chk("reset_fault", {31'b0, fault}, 32'h0);
        chk("reset_fault_pc", fault_pc, 32'h0);
        do_op(1'b0, 1'b0, MB, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("reset_cycle", rd, 32'h0);

        tbl.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h00000000});
        tbl.push_back('{1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 32'h14, 32'h11223344, 2'b00, 1'b0, 32'h00000000});
        tbl.push_back('{1'b1, 32'h15, 32'h000000AB, 2'b10, 1'b0, 32'h00000033});
        tbl.push_back('{1'b0, 32'h14, 32'h0,        2'b00, 1'b0, 32'h1122AB44});
        tbl.push_back('{1'b0, 32'h15, 32'h0,        2'b10, 1'b0, 32'hFFFFFFAB});
        tbl.push_back('{1'b0, 32'h15, 32'h0,        2'b10, 1'b1, 32'h000000AB});
        tbl.push_back('{1'b1, 32'h22, 32'h00008001, 2'b01, 1'b0, 32'h00000000});
        tbl.push_back('{1'b0, 32'h20, 32'h0,        2'b00, 1'b0, 32'h80010000});
        tbl.push_back('{1'b0, 32'h22, 32'h0,        2'b01, 1'b0, 32'hFFFF8001});
        tbl.push_back('{1'b0, 32'h22, 32'h0,        2'b01, 1'b1, 32'h00008001});
        tbl.push_back('{1'b0, 32'h23, 32'h0,        2'b01, 1'b1, 32'h00008001});
        tbl.push_back('{1'b0, 32'h12, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF});
        foreach (tbl[i]) begin
            do_op(1'b0, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].whb, tbl[i].lun, 32'h0, 1'b1, rd);
            chk($sformatf("vec%0d", i), rd, tbl[i].exp);
        end

        do_op(1'b0, 1'b1, 32'h23, 32'hFFFF, 2'b01, 1'b0, 32'h40, 1'b1, rd);
        chk("misal_sh_fault", {31'b0, fault}, 32'h1);
        chk("misal_sh_fpc", fault_pc, 32'h40);
        do_op(1'b0, 1'b0, 32'h20, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("misal_sh_ram_kept", rd, 32'h80010000);
        do_op(1'b0, 1'b1, 32'h21, 32'h0, 2'b00, 1'b0, 32'h80, 1'b1, rd);
        chk("second_misal_fpc", fault_pc, 32'h40);
        do_op(1'b0, 1'b1, MB + 32'h8, 32'h1, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("w1c_fault", {31'b0, fault}, 32'h0);
        chk("w1c_fpc_kept", fault_pc, 32'h40);
        do_op(1'b0, 1'b1, 32'h23, 32'h77, 2'b10, 1'b0, 32'hC0, 1'b1, rd);
        chk("sb_no_fault", {31'b0, fault}, 32'h0);
        do_op(1'b0, 1'b1, 32'h11, 32'h0, 2'b11, 1'b0, 32'hC4, 1'b1, rd);
        chk("rsvd_no_fault", {31'b0, fault}, 32'h0);
        do_op(1'b0, 1'b0, 32'h10, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("rsvd_ram_kept", rd, 32'hDEADBEEF);
        do_op(1'b0, 1'b1, 32'h26, 32'h0, 2'b00, 1'b0, 32'h100, 1'b1, rd);
        chk("rearm_fpc", fault_pc, 32'h100);
        do_op(1'b0, 1'b0, MB + 32'hC, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("fpc_mmio_read", rd, 32'h100);
        do_op(1'b0, 1'b1, MB + 32'h8, 32'h1, 2'b00, 1'b0, 0, 1'b1, rd);

        do_op(1'b0, 1'b1, MB + 32'h4, 32'h1234ABCD, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("led_sw", {16'b0, leds}, 32'hABCD);
        do_op(1'b0, 1'b1, MB + 32'h4, 32'h55, 2'b10, 1'b0, 0, 1'b1, rd);
        chk("led_sb_ignored", {16'b0, leds}, 32'hABCD);
        chk("led_sb_no_fault", {31'b0, fault}, 32'h0);
        do_op(1'b0, 1'b0, MB + 32'h4, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("led_lw", rd, 32'h0000ABCD);
        do_op(1'b0, 1'b0, MB + 32'h5, 0, 2'b10, 1'b1, 0, 1'b1, rd);
        chk("led_lbu", rd, 32'h000000AB);

        do_op(1'b1, 1'b0, 0, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        for (int i = 0; i < 5; i++) do_op(1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        do_op(1'b0, 1'b0, MB, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("cycle_after_5", rd, 32'd5);
        do_op(1'b0, 1'b1, MB + 32'h4, 32'h5A5A, 2'b00, 1'b0, 0, 1'b1, rd);
        do_op(1'b1, 1'b1, MB + 32'h4, 32'h1111, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("reset_beats_led", {16'b0, leds}, 32'h0);
        do_op(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 2'b00, 1'b0, 0, 1'b1, rd);
        do_op(1'b0, 1'b0, 32'h30, 0, 2'b00, 1'b0, 0, 1'b1, rd);
        chk("ram_store_in_reset", rd, 32'hCAFEF00D);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) ra = MB | 32'($urandom_range(0, 31));
            else if (r < 3) begin
                ra = $urandom;
                if (ra[31:8] == 24'hFFFF00) ra[16] = 1'b0;
            end else ra = 32'($urandom_range(0, 255));
            do_op(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, ra, $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom, 1'b1, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
